wb_cp0_ext: RTL and testbench
=============================

// Module: wb_cp0_ext
// PURPOSE
//  Parametrised write-back stage with extended CP0 for the 5-stage pipeline. Commits
//  register/HI/LO writes, takes precise exceptions and interrupts, handles ERET.
//  Supports multiple exception causes, BadVAddr, a Count/Compare timer, and masked
//  hardware interrupts. Drives the fetch redirect and the pipeline cancel.
// PARAMETERS
//  EXC_ENTER_ADDR  32'd0  exception/interrupt vector driven on exc_pc
//  HW_INT_NUM      5      hardware interrupt lines, 1..5, mapped to Cause.IP[2+i]
//  COUNT_DIV       2      Count increments once every COUNT_DIV cycles (>=1)
// PORTS
//  clk           in   1    clock
//  resetn        in   1    synchronous reset, active low
//  WB_valid      in   1    WB holds a valid instruction
//  wen           in   1    instruction writes GPR
//  wdest         in   5    GPR destination
//  mem_result    in   32   GPR result; HI data; mtc0 data
//  lo_result     in   32   LO data
//  hi_write      in   1    write HI
//  lo_write      in   1    write LO
//  mfhi,mflo     in   1    select HI / LO as GPR data
//  mtc0,mfc0     in   1    CP0 write / read
//  cp0r_addr     in   8    {rd[4:0],sel[2:0]}
//  exc_valid_in  in   1    instruction raised an exception in an earlier stage
//  exc_code_in   in   5    its ExcCode (4 AdEL,5 AdES,8 Sys,9 Bp,10 RI,12 Ov)
//  badvaddr_in   in   32   faulting address for codes 4/5
//  eret          in   1    instruction is ERET
//  pc            in   32   instruction PC
//  hw_int        in   HW_INT_NUM  level-sensitive hardware interrupts
//  rf_wen,rf_wdest,rf_wdata  out 1/5/32  register-file write port
//  WB_over       out  1    = WB_valid
//  WB_wdest      out  5    rf_wdest masked by WB_valid, zeroed if instruction is squashed
//  exc_bus       out  33   {exc_valid, exc_pc}
//  cancel        out  1    = exc_valid
//  HI_data,LO_data out 32  HI/LO contents
// BEHAVIOUR
//  CP0 registers (sel 0), reset value 0 unless stated otherwise:
//   8 BadVAddr (RO); 9 Count (RW); 11 Compare (RW).
//   12 Status: IM[15:8] RW, EXL[1] RW, IE[0] RW; EXL resets to 1.
//   13 Cause: TI[30] RO, IP[15:10] RO hardware, IP[9:8] RW software, ExcCode[6:2] RO.
//   14 EPC (RW).
//   Unlisted addresses read 0; writes to them are ignored.
//  hw_int is registered once into Cause.IP[2+i], giving 1-cycle sampling latency.
//   Unused IP bits read 0. IP[7] = TI.
//  Count: prescaler 0..COUNT_DIV-1; Count+1 (wrap 2^32) when prescaler = COUNT_DIV-1.
//   mtc0 Count wins over increment and clears the prescaler.
//  TI: set in the cycle after Count==Compare while Count increments. Cleared by mtc0
//   Compare; the clear wins over a set in the same cycle.
//  int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
//  exc_valid = WB_valid & (int_req | exc_valid_in | eret).
//   Priority: interrupt > exc_valid_in > eret.
//  Interrupt or exception (combinational, same cycle):
//   - rf_wen=0, no HI/LO/CP0 write by this instruction, exc_pc = EXC_ENTER_ADDR.
//   Next edge:
//   - EPC <= pc, EXL <= 1, ExcCode <= 0 for an interrupt, else exc_code_in.
//   - BadVAddr <= badvaddr_in only for codes 4/5.
//  ERET (no int/exception): exc_pc = EPC (value before this edge); next edge EXL <= 0.
//  Normal commit: rf_wen = wen & WB_valid.
//   rf_wdata = mfhi ? HI : mflo ? LO : mfc0 ? cp0_rdata : mem_result.
//   HI/LO updated on hi_write/lo_write gated by WB_valid.
//  All writes are gated by WB_valid, so nothing happens with WB_valid=0.
//  Timer/IP updates continue while WB_valid=0; a pending interrupt waits for a valid
//   instruction.
//  Reset (resetn=0 at an edge) clears HI, LO, and all CP0 state except EXL=1.
//   Reset overrides any simultaneous event. Outputs are combinational from state and
//   inputs, so exc_valid=0 while WB_valid=0.
// TESTING
//  1 mtc0 Compare=10, Count=0, COUNT_DIV=2, IM7=1, IE=1, EXL=0 -> TI set about 20
//    cycles later; next valid instr: exc_pc=0, EPC=its pc, ExcCode=0, rf_wen=0.
//  2 exc_valid_in, code 4, badvaddr 0x1003 -> BadVAddr=0x1003, Cause=0x10,
//    EXL=1, cancel=1.
//  3 ERET with EPC=0x0BFC0040 -> exc_pc=0x0BFC0040, EXL=0 next cycle,
//    no GPR write.
//  4 hw_int[0]=1 with EXL=1 -> no interrupt; ERET clears EXL, next instr
//    is interrupted.
//  5 mtc0 Compare in the same cycle TI would set -> TI stays 0.
//  6 mult then mfhi/mflo, reset asserted mid-stream -> HI/LO = 0, EXL=1,
//    exc_valid=0.

Source files
------------

// File: rtl/wb_cp0_ext_if.sv
// Write-back stage bus: instruction/commit controls in, register-file write port,
// fetch redirect and HI/LO contents out.
interface wb_cp0_ext_if #(
  parameter int unsigned HW_INT_NUM = 5
);
  logic                  WB_valid;
  logic                  wen;
  logic [4:0]            wdest;
  logic [31:0]           mem_result;
  logic [31:0]           lo_result;
  logic                  hi_write;
  logic                  lo_write;
  logic                  mfhi;
  logic                  mflo;
  logic                  mtc0;
  logic                  mfc0;
  logic [7:0]            cp0r_addr;
  logic                  exc_valid_in;
  logic [4:0]            exc_code_in;
  logic [31:0]           badvaddr_in;
  logic                  eret;
  logic [31:0]           pc;
  logic [HW_INT_NUM-1:0] hw_int;

  logic                  rf_wen;
  logic [4:0]            rf_wdest;
  logic [31:0]           rf_wdata;
  logic                  WB_over;
  logic [4:0]            WB_wdest;
  logic [32:0]           exc_bus;
  logic                  cancel;
  logic [31:0]           HI_data;
  logic [31:0]           LO_data;

  modport slave (
    input  WB_valid, wen, wdest, mem_result, lo_result, hi_write, lo_write,
           mfhi, mflo, mtc0, mfc0, cp0r_addr, exc_valid_in, exc_code_in,
           badvaddr_in, eret, pc, hw_int,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_bus, cancel,
           HI_data, LO_data
  );

  modport master (
    output WB_valid, wen, wdest, mem_result, lo_result, hi_write, lo_write,
           mfhi, mflo, mtc0, mfc0, cp0r_addr, exc_valid_in, exc_code_in,
           badvaddr_in, eret, pc, hw_int,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_bus, cancel,
           HI_data, LO_data
  );
endinterface

// File: rtl/wb_cp0_ext.sv
// Write-back stage with extended CP0: commits GPR/HI/LO writes, takes precise
// exceptions and masked interrupts (hardware, software, Count/Compare timer), handles ERET.
module wb_cp0_ext #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'd0,
  parameter int unsigned HW_INT_NUM     = 5,
  parameter int unsigned COUNT_DIV      = 2
) (
  input  logic          clk,
  input  logic          resetn,
  wb_cp0_ext_if.slave   wb
);
  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;

  logic [31:0]           hi, lo;
  logic [31:0]           badvaddr, count, compare, epc;
  logic [PW-1:0]         presc;
  logic                  ti;
  logic [7:0]            im;
  logic                  exl, ie;
  logic [1:0]            sw_ip;
  logic [HW_INT_NUM-1:0] hw_ip;
  logic [4:0]            exc_code;

  logic [7:0]  ip;
  logic        int_req;
  logic        take_int, take_exc, take_eret, exc_valid, commit;
  logic        cp0_wen, count_tick, count_wr, compare_wr;
  logic [31:0] status_val, cause_val, cp0_rdata, exc_pc;

  always_comb begin
    ip = '0;
    ip[1:0] = sw_ip;
    for (int unsigned i = 0; i < HW_INT_NUM; i++) ip[2+i] = hw_ip[i];
    ip[7] = ti;
  end

  assign int_req   = ie & ~exl & (|(ip & im));
  // Interrupt outranks a pipeline exception, which outranks ERET.
  assign take_int  = wb.WB_valid & int_req;
  assign take_exc  = wb.WB_valid & ~int_req & wb.exc_valid_in;
  assign take_eret = wb.WB_valid & ~int_req & ~wb.exc_valid_in & wb.eret;
  assign exc_valid = take_int | take_exc | take_eret;
  assign commit    = wb.WB_valid & ~exc_valid;

  assign cp0_wen    = commit & wb.mtc0;
  assign count_tick = (presc == PRESC_MAX);
  assign count_wr   = cp0_wen & (wb.cp0r_addr == A_COUNT);
  assign compare_wr = cp0_wen & (wb.cp0r_addr == A_COMPARE);

  assign status_val = {16'b0, im, 6'b0, exl, ie};
  assign cause_val  = {1'b0, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};

  always_comb begin
    cp0_rdata = '0;
    case (wb.cp0r_addr)
      A_BADVADDR: cp0_rdata = badvaddr;
      A_COUNT:    cp0_rdata = count;
      A_COMPARE:  cp0_rdata = compare;
      A_STATUS:   cp0_rdata = status_val;
      A_CAUSE:    cp0_rdata = cause_val;
      A_EPC:      cp0_rdata = epc;
      default:    cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi       <= '0;
      lo       <= '0;
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      presc    <= '0;
      ti       <= 1'b0;
      im       <= '0;
      exl      <= 1'b1;
      ie       <= 1'b0;
      sw_ip    <= '0;
      hw_ip    <= '0;
      exc_code <= '0;
    end else begin
      hw_ip <= wb.hw_int;

      if (count_wr) begin
        count <= wb.mem_result;
        presc <= '0;
      end else if (count_tick) begin
        count <= count + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      // The match is judged on the pre-increment Count; a Compare write clears and wins.
      if (compare_wr)
        ti <= 1'b0;
      else if (count_tick && !count_wr && count == compare)
        ti <= 1'b1;

      if (take_int || take_exc) begin
        epc      <= wb.pc;
        exl      <= 1'b1;
        exc_code <= take_int ? 5'd0 : wb.exc_code_in;
        if (take_exc && (wb.exc_code_in == 5'd4 || wb.exc_code_in == 5'd5))
          badvaddr <= wb.badvaddr_in;
      end else if (take_eret) begin
        exl <= 1'b0;
      end else if (cp0_wen) begin
        case (wb.cp0r_addr)
          A_COMPARE: compare <= wb.mem_result;
          A_STATUS: begin
            im  <= wb.mem_result[15:8];
            exl <= wb.mem_result[1];
            ie  <= wb.mem_result[0];
          end
          A_CAUSE:   sw_ip <= wb.mem_result[9:8];
          A_EPC:     epc   <= wb.mem_result;
          default: ;
        endcase
      end

      if (commit && wb.hi_write) hi <= wb.mem_result;
      if (commit && wb.lo_write) lo <= wb.lo_result;
    end
  end

  assign exc_pc = (take_int || take_exc) ? EXC_ENTER_ADDR :
                  take_eret              ? epc : '0;

  assign wb.rf_wen   = commit & wb.wen;
  assign wb.rf_wdest = wb.wdest;
  assign wb.rf_wdata = wb.mfhi ? hi :
                       wb.mflo ? lo :
                       wb.mfc0 ? cp0_rdata : wb.mem_result;
  assign wb.WB_over  = wb.WB_valid;
  assign wb.WB_wdest = commit ? wb.wdest : '0;
  assign wb.exc_bus  = {exc_valid, exc_pc};
  assign wb.cancel   = exc_valid;
  assign wb.HI_data  = hi;
  assign wb.LO_data  = lo;
endmodule

// File: tb/tb_wb_cp0_ext.sv
// Bench for wb_cp0_ext: directed scenarios then random traffic, every cycle compared
// against a register-image reference model of the write-back stage and CP0.
module tb_wb_cp0_ext;
  localparam logic [31:0] EXC = 32'h0000_0380;
  localparam int unsigned HWN = 5;
  localparam int unsigned DIV = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  wb_cp0_ext_if #(.HW_INT_NUM(HWN)) wb ();

  wb_cp0_ext #(.EXC_ENTER_ADDR(EXC), .HW_INT_NUM(HWN), .COUNT_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .wb(wb)
  );

  always #5 clk = ~clk;

  // Reference model: whole-word register images; Cause keeps only its writable/latched
  // fields here, TI and sampled hardware lines are merged in on read.
  logic [31:0] m_hi, m_lo, m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_ti;
  logic [4:0]  m_hwip;
  int unsigned m_presc;

  function automatic logic [31:0] cause_full();
    return m_cause | (32'(m_ti) << 30) | (32'(m_ti) << 15) | (32'(m_hwip) << 10);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[2:0] != 3'd0) return 32'd0;
    case (a[7:3])
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return cause_full();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_intreq();
    logic [31:0] cf;
    cf = cause_full();
    return m_status[0] && !m_status[1] && ((cf[15:8] & m_status[15:8]) != 8'd0);
  endfunction

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    wb.WB_valid = 0; wb.wen = 0; wb.wdest = 5'd0; wb.mem_result = 32'd0;
    wb.lo_result = 32'd0; wb.hi_write = 0; wb.lo_write = 0; wb.mfhi = 0; wb.mflo = 0;
    wb.mtc0 = 0; wb.mfc0 = 0; wb.cp0r_addr = 8'd0; wb.exc_valid_in = 0;
    wb.exc_code_in = 5'd0; wb.badvaddr_in = 32'd0; wb.eret = 0; wb.pc = 32'h0000_1000;
  endtask

  // One clock: compare all outputs against the model, then advance the model at the edge.
  task automatic cycle();
    bit intr, exc, er, commit, tick, cw, setti, clrti;
    logic [31:0] e_pc, e_wdata;
    logic [31:0] n_hi, n_lo, n_badv, n_count, n_compare, n_status, n_cause, n_epc;
    logic n_ti;
    int unsigned n_presc;
    #1;
    intr   = wb.WB_valid && m_intreq();
    exc    = wb.WB_valid && !intr && wb.exc_valid_in;
    er     = wb.WB_valid && !intr && !exc && wb.eret;
    commit = wb.WB_valid && !(intr || exc || er);
    e_pc   = (intr || exc) ? EXC : (er ? m_epc : 32'd0);
    e_wdata = wb.mfhi ? m_hi : wb.mflo ? m_lo : wb.mfc0 ? m_read(wb.cp0r_addr) : wb.mem_result;

    check("exc_bus",  wb.exc_bus, {(intr || exc || er), e_pc});
    check("cancel",   33'(wb.cancel), 33'(intr || exc || er));
    check("rf_wen",   33'(wb.rf_wen), 33'(commit && wb.wen));
    check("rf_wdest", 33'(wb.rf_wdest), 33'(wb.wdest));
    check("rf_wdata", 33'(wb.rf_wdata), 33'(e_wdata));
    check("WB_over",  33'(wb.WB_over), 33'(wb.WB_valid));
    check("WB_wdest", 33'(wb.WB_wdest), commit ? 33'(wb.wdest) : 33'd0);
    check("HI_data",  33'(wb.HI_data), 33'(m_hi));
    check("LO_data",  33'(wb.LO_data), 33'(m_lo));

    n_hi = m_hi; n_lo = m_lo; n_badv = m_badv; n_count = m_count; n_compare = m_compare;
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_ti = m_ti; n_presc = m_presc;

    tick = (m_presc == DIV - 1);
    cw   = commit && wb.mtc0 && wb.cp0r_addr == 8'h48;
    if (cw) begin
      n_count = wb.mem_result; n_presc = 0;
    end else begin
      n_presc = tick ? 0 : m_presc + 1;
      n_count = m_count + (tick ? 32'd1 : 32'd0);
    end
    setti = tick && !cw && (m_count == m_compare);
    clrti = commit && wb.mtc0 && wb.cp0r_addr == 8'h58;
    n_ti  = clrti ? 1'b0 : (setti ? 1'b1 : m_ti);

    if (intr || exc) begin
      n_epc    = wb.pc;
      n_status = m_status | 32'h2;
      n_cause  = (m_cause & 32'h300) | (intr ? 32'd0 : (32'(wb.exc_code_in) << 2));
      if (exc && (wb.exc_code_in == 5'd4 || wb.exc_code_in == 5'd5)) n_badv = wb.badvaddr_in;
    end else if (er) begin
      n_status = m_status & ~32'h2;
    end else if (commit && wb.mtc0) begin
      case (wb.cp0r_addr)
        8'h58: n_compare = wb.mem_result;
        8'h60: n_status  = wb.mem_result & 32'h0000_FF03;
        8'h68: n_cause   = (m_cause & 32'h7C) | (wb.mem_result & 32'h300);
        8'h70: n_epc     = wb.mem_result;
        default: ;
      endcase
    end
    if (commit && wb.hi_write) n_hi = wb.mem_result;
    if (commit && wb.lo_write) n_lo = wb.lo_result;

    @(posedge clk);
    if (!resetn) begin
      m_hi = 0; m_lo = 0; m_badv = 0; m_count = 0; m_compare = 0; m_status = 32'h2;
      m_cause = 0; m_epc = 0; m_ti = 0; m_hwip = 0; m_presc = 0;
    end else begin
      m_hi = n_hi; m_lo = n_lo; m_badv = n_badv; m_count = n_count; m_compare = n_compare;
      m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_ti = n_ti;
      m_hwip = wb.hw_int; m_presc = n_presc;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      clear_inputs();
      cycle();
    end
  endtask

  task automatic do_mtc0(input logic [7:0] a, input logic [31:0] d);
    clear_inputs();
    wb.WB_valid = 1; wb.mtc0 = 1; wb.cp0r_addr = a; wb.mem_result = d;
    cycle();
  endtask

  task automatic expect_cp0(input string tag, input logic [7:0] a, input logic [31:0] exp);
    clear_inputs();
    wb.WB_valid = 1; wb.mfc0 = 1; wb.wen = 1; wb.wdest = 5'd3; wb.cp0r_addr = a;
    #1;
    check(tag, 33'(wb.rf_wdata), 33'(exp));
    cycle();
  endtask

  initial begin
    logic [7:0] addrs [10];
    logic [4:0] codes [6];
    addrs = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h49, 8'h00, 8'hF8, 8'h61};
    codes = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    m_hi = 0; m_lo = 0; m_badv = 0; m_count = 0; m_compare = 0; m_status = 32'h2;
    m_cause = 0; m_epc = 0; m_ti = 0; m_hwip = 0; m_presc = 0;
    clear_inputs();
    wb.hw_int = '0;
    resetn = 0;
    idle(2);
    resetn = 1;
    check("reset_exc_bus", wb.exc_bus, 33'd0);
    expect_cp0("reset_status", 8'h60, 32'h0000_0002);

    // Timer interrupt
    do_mtc0(8'h58, 32'd10);
    do_mtc0(8'h48, 32'd0);
    do_mtc0(8'h60, 32'h0000_8001);
    idle(24);
    clear_inputs();
    wb.WB_valid = 1; wb.wen = 1; wb.wdest = 5'd7; wb.pc = 32'h0000_0100;
    #1;
    check("timer_exc_bus", wb.exc_bus, {1'b1, EXC});
    check("timer_rf_wen", 33'(wb.rf_wen), 33'd0);
    cycle();
    expect_cp0("timer_epc", 8'h70, 32'h0000_0100);
    expect_cp0("timer_cause", 8'h68, 32'h4000_8000);
    expect_cp0("timer_status", 8'h60, 32'h0000_8003);

    // Address error
    do_mtc0(8'h58, 32'hFFFF_FFFF);
    clear_inputs();
    wb.WB_valid = 1; wb.exc_valid_in = 1; wb.exc_code_in = 5'd4;
    wb.badvaddr_in = 32'h0000_1003; wb.pc = 32'h0000_0200;
    #1;
    check("adel_cancel", 33'(wb.cancel), 33'd1);
    cycle();
    expect_cp0("adel_badvaddr", 8'h40, 32'h0000_1003);
    expect_cp0("adel_cause", 8'h68, 32'h0000_0010);
    expect_cp0("adel_status", 8'h60, 32'h0000_8003);

    // ERET
    do_mtc0(8'h70, 32'h0BFC_0040);
    clear_inputs();
    wb.WB_valid = 1; wb.eret = 1; wb.wen = 1; wb.wdest = 5'd4;
    #1;
    check("eret_exc_bus", wb.exc_bus, {1'b1, 32'h0BFC_0040});
    check("eret_rf_wen", 33'(wb.rf_wen), 33'd0);
    cycle();
    expect_cp0("eret_status", 8'h60, 32'h0000_8001);

    // Hardware interrupt held off by EXL until ERET
    do_mtc0(8'h60, 32'h0000_0403);
    wb.hw_int = 5'b00001;
    clear_inputs();
    wb.WB_valid = 1;
    #1;
    check("hwint_exl_masked", 33'(wb.cancel), 33'd0);
    cycle();
    clear_inputs();
    wb.WB_valid = 1; wb.eret = 1;
    cycle();
    clear_inputs();
    wb.WB_valid = 1; wb.pc = 32'h0000_0300;
    #1;
    check("hwint_taken", wb.exc_bus, {1'b1, EXC});
    cycle();
    wb.hw_int = '0;
    idle(1);
    expect_cp0("hwint_epc", 8'h70, 32'h0000_0300);
    expect_cp0("hwint_cause", 8'h68, 32'h0000_0000);

    // Compare write coincides with the timer match
    do_mtc0(8'h48, 32'd0);
    do_mtc0(8'h58, 32'd1);
    idle(2);
    do_mtc0(8'h58, 32'd1);
    expect_cp0("ti_clear_wins", 8'h68, 32'h0000_0000);

    // HI/LO, then reset mid-stream
    clear_inputs();
    wb.WB_valid = 1; wb.hi_write = 1; wb.lo_write = 1;
    wb.mem_result = 32'h1234_5678; wb.lo_result = 32'h9ABC_DEF0;
    cycle();
    clear_inputs();
    wb.WB_valid = 1; wb.mfhi = 1; wb.wen = 1; wb.wdest = 5'd2;
    #1;
    check("mfhi_data", 33'(wb.rf_wdata), 33'h1234_5678);
    cycle();
    clear_inputs();
    wb.WB_valid = 1; wb.mflo = 1; wb.wen = 1; wb.wdest = 5'd2;
    #1;
    check("mflo_data", 33'(wb.rf_wdata), 33'h9ABC_DEF0);
    cycle();
    clear_inputs();
    wb.WB_valid = 1; wb.hi_write = 1; wb.mem_result = 32'h5555_AAAA;
    resetn = 0;
    cycle();
    resetn = 1;
    clear_inputs();
    wb.eret = 1; wb.exc_valid_in = 1;
    #1;
    check("rst_hi", 33'(wb.HI_data), 33'd0);
    check("rst_lo", 33'(wb.LO_data), 33'd0);
    check("rst_no_exc", wb.exc_bus, 33'd0);
    cycle();
    expect_cp0("rst_status", 8'h60, 32'h0000_0002);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      resetn          = ($urandom_range(0, 299) != 0);
      wb.WB_valid     = ($urandom_range(0, 3) != 0);
      wb.wen          = 1'($urandom);
      wb.wdest        = 5'($urandom);
      wb.mem_result   = $urandom;
      wb.lo_result    = $urandom;
      wb.hi_write     = ($urandom_range(0, 7) == 0);
      wb.lo_write     = ($urandom_range(0, 7) == 0);
      wb.mfhi         = ($urandom_range(0, 7) == 0);
      wb.mflo         = ($urandom_range(0, 7) == 0);
      wb.mfc0         = ($urandom_range(0, 3) == 0);
      wb.mtc0         = ($urandom_range(0, 3) == 0);
      wb.cp0r_addr    = addrs[$urandom_range(0, 9)];
      if ((wb.cp0r_addr == 8'h48 || wb.cp0r_addr == 8'h58) && $urandom_range(0, 1) == 1)
        wb.mem_result = 32'($urandom_range(0, 15));
      if (wb.cp0r_addr == 8'h60 && $urandom_range(0, 1) == 1)
        wb.mem_result = 32'hFF01;
      wb.exc_valid_in = ($urandom_range(0, 15) == 0);
      wb.exc_code_in  = codes[$urandom_range(0, 5)];
      wb.badvaddr_in  = $urandom;
      wb.eret         = ($urandom_range(0, 15) == 0);
      wb.pc           = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) wb.hw_int = 5'($urandom);
      cycle();
    end
    resetn = 1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
